// File: rtl/tft_pkg.sv
// tft_pkg: shared definitions for the TFT SPI command path.
//   tft_state_e     - transmitter phase encoding (IDLE, LOW, HIGH, HOLD)
//   DC_COMM/DC_DATA - encoding of the panel D/C line
//   CLK_DIV_DEFAULT - default clk cycles per SCK half-period
package tft_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      HOLD = 2'd3
   } tft_state_e;

   localparam logic DC_COMM = 1'b0;
   localparam logic DC_DATA = 1'b1;

   localparam int unsigned CLK_DIV_DEFAULT = 2;

endpackage

// File: rtl/tft_spi_tick.sv
// tft_spi_tick: reloadable down-counter that paces every SPI phase.
// A load restarts the phase; tick is high during the last of the
// CLK_DIV cycles that follow the load.
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   load - restart the count (asserted on every phase change)
//   tick - current phase has lasted CLK_DIV cycles
module tft_spi_tick
   import tft_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Counting down to zero and holding there: no wrap between phases,
   // the FSM always reloads on the cycle it changes state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/tft_spi_tx.sv
// tft_spi_tx: byte-level SPI mode-0 transmitter for the TFT panel.
// Takes one byte plus its D/C flag over a transmit/busy handshake and
// shifts it out MSB first. Owns chip select and the D/C pin.
//   clk, rst      - system clock, asynchronous active-high reset
//   tft_transmit  - single-cycle request, honoured only while tft_busy=0
//   tft_dc        - 0=command, 1=data; captured with the request
//   tft_data      - byte to send; captured with the request
//   tft_busy      - a byte is in flight (17*CLK_DIV cycles)
//   overrun       - sticky: a request arrived while busy
//   spi_sck       - serial clock, idle low
//   spi_mosi      - serial data, MSB first
//   spi_cs_n      - chip select, active low
//   spi_dc        - D/C pin, holds the last accepted flag
module tft_spi_tx
   import tft_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tft_transmit,
   input  logic       tft_dc,
   input  logic [7:0] tft_data,
   output logic       tft_busy,
   output logic       overrun,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_cs_n,
   output logic       spi_dc
);

   tft_state_e state, state_d;

   logic       tick;
   logic       load;
   logic       accept;
   logic       shift;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;

   tft_spi_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Every state change reloads the divider so each phase lasts exactly
   // CLK_DIV cycles measured from its own entry.
   always_comb begin
      state_d = state;
      load    = 1'b0;
      accept  = 1'b0;
      shift   = 1'b0;
      case (state)
         IDLE: begin
            if (tft_transmit && !tft_busy) begin
               accept  = 1'b1;
               load    = 1'b1;
               state_d = LOW;
            end
         end
         LOW: begin
            if (tick) begin
               load    = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (tick) begin
               load = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_d = HOLD;
               end else begin
                  shift   = 1'b1;
                  state_d = LOW;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               load    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shift register carries no control meaning, so it is left unreset;
   // it is always loaded on accept before any bit is driven from it.
   always_ff @(posedge clk) begin
      if (accept) begin
         shreg <= tft_data;
      end else if (shift) begin
         shreg <= {shreg[6:0], 1'b0};
      end
   end

   // Outputs are registered from the next state so they line up with
   // the phase the FSM is entering. MOSI moves only on LOW entry, i.e.
   // at the start of the byte or on the falling SCK edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt  <= 3'd0;
         spi_mosi <= 1'b0;
         spi_dc   <= DC_COMM;
         tft_busy <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_sck  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (accept) begin
            bit_cnt  <= 3'd0;
            spi_mosi <= tft_data[7];
            spi_dc   <= tft_dc;
         end else if (shift) begin
            bit_cnt  <= bit_cnt + 3'd1;
            spi_mosi <= shreg[6];
         end
         tft_busy <= (state_d != IDLE);
         spi_cs_n <= (state_d == IDLE);
         spi_sck  <= (state_d == HIGH);
         if (tft_transmit && tft_busy) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tft_spi_tx.sv
module tb_tft_spi_tx;

   localparam int D0 = 2;
   localparam int D1 = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       tx   [2];
   logic       dci  [2];
   logic [7:0] dat  [2];
   logic       busy [2];
   logic       ovr  [2];
   logic       sck  [2];
   logic       mosi [2];
   logic       csn  [2];
   logic       dco  [2];

   tft_spi_tx #(.CLK_DIV(D0)) u0 (
      .clk(clk), .rst(rst), .tft_transmit(tx[0]), .tft_dc(dci[0]), .tft_data(dat[0]),
      .tft_busy(busy[0]), .overrun(ovr[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
      .spi_cs_n(csn[0]), .spi_dc(dco[0]));

   tft_spi_tx #(.CLK_DIV(D1)) u1 (
      .clk(clk), .rst(rst), .tft_transmit(tx[1]), .tft_dc(dci[1]), .tft_data(dat[1]),
      .tft_busy(busy[1]), .overrun(ovr[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
      .spi_cs_n(csn[1]), .spi_dc(dco[1]));

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-offset arithmetic) ----------
   typedef struct {
      int         inst;
      logic       dc;
      logic [7:0] data;
   } frame_t;

   frame_t     exp_q[$];
   int         divs [2] = '{D0, D1};
   bit         m_act [2];
   int         m_k   [2];
   logic [7:0] m_data[2];
   logic       m_dc  [2];
   logic       m_mosi[2];
   logic       m_ovr [2];

   task automatic model_reset(input int i);
      m_act[i] = 0; m_k[i] = 0; m_data[i] = 8'h00;
      m_dc[i] = 1'b0; m_mosi[i] = 1'b0; m_ovr[i] = 1'b0;
      for (int j = exp_q.size() - 1; j >= 0; j--)
         if (exp_q[j].inst == i) exp_q.delete(j);
   endtask

   // Advances the model over one rising edge using the inputs in force.
   // After acceptance the byte occupies offsets k = 0 .. 17*D-1.
   task automatic model_step(input int i);
      bit was_busy;
      int d;
      frame_t f;
      d = divs[i];
      if (rst) begin
         model_reset(i);
         return;
      end
      was_busy = m_act[i];
      if (m_act[i]) begin
         m_k[i]++;
         if (m_k[i] == 17 * d) m_act[i] = 0;
      end else if (tx[i]) begin
         m_act[i] = 1; m_k[i] = 0; m_data[i] = dat[i]; m_dc[i] = dci[i];
         f.inst = i; f.dc = dci[i]; f.data = dat[i];
         exp_q.push_back(f);
      end
      if (tx[i] && was_busy) m_ovr[i] = 1'b1;
      if (m_act[i] && m_k[i] < 16 * d) m_mosi[i] = m_data[i][7 - m_k[i] / (2 * d)];
   endtask

   // ---------------- SPI monitor state ----------------
   logic       prev_sck[2], prev_csn[2];
   logic [7:0] mon_sh[2];
   int         mon_n[2], gap_cnt[2], last_gap[2], busy_run[2], last_len[2], frames[2];
   logic [7:0] last_byte[2];
   logic       last_dc[2];

   task automatic mon_reset(input int i);
      prev_sck[i] = 1'b0; prev_csn[i] = 1'b1; mon_sh[i] = 8'h00; mon_n[i] = 0;
      gap_cnt[i] = 0; busy_run[i] = 0;
   endtask

   task automatic check_out(input int i);
      int d, idx;
      logic exp_sck;
      d = divs[i];
      exp_sck = m_act[i] && (m_k[i] < 16 * d) && (((m_k[i] / d) % 2) == 1);
      chk($sformatf("busy%0d", i), busy[i], m_act[i]);
      chk($sformatf("cs_n%0d", i), csn[i], !m_act[i]);
      chk($sformatf("sck%0d", i),  sck[i], exp_sck);
      chk($sformatf("mosi%0d", i), mosi[i], m_mosi[i]);
      chk($sformatf("dc%0d", i),   dco[i], m_dc[i]);
      chk($sformatf("ovr%0d", i),  ovr[i], m_ovr[i]);
      if (rst) begin
         mon_reset(i);
         return;
      end
      if (busy[i]) busy_run[i]++;
      else if (busy_run[i] > 0) begin last_len[i] = busy_run[i]; busy_run[i] = 0; end
      if (prev_csn[i] && !csn[i]) begin
         mon_n[i] = 0; last_gap[i] = gap_cnt[i]; gap_cnt[i] = 0;
      end
      if (!csn[i] && sck[i] && !prev_sck[i]) begin
         mon_sh[i] = {mon_sh[i][6:0], mosi[i]};
         mon_n[i]++;
      end
      if (csn[i]) gap_cnt[i]++;
      if (!prev_csn[i] && csn[i]) begin
         frames[i]++;
         last_byte[i] = mon_sh[i];
         last_dc[i] = dco[i];
         chk($sformatf("bitcount%0d", i), mon_n[i], 8);
         idx = -1;
         foreach (exp_q[j]) if (idx < 0 && exp_q[j].inst == i) idx = j;
         if (idx < 0) chk($sformatf("frame_unexpected%0d", i), 1, 0);
         else begin
            chk($sformatf("frame_data%0d", i), mon_sh[i], exp_q[idx].data);
            chk($sformatf("frame_dc%0d", i), dco[i], exp_q[idx].dc);
            exp_q.delete(idx);
         end
      end
      prev_sck[i] = sck[i];
      prev_csn[i] = csn[i];
   endtask

   task automatic cyc();
      model_step(0);
      model_step(1);
      @(posedge clk);
      @(negedge clk);
      check_out(0);
      check_out(1);
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      while (busy[i] && n < 300) begin cyc(); n++; end
      if (busy[i]) chk("idle_timeout", 1, 0);
   endtask

   task automatic send(input int i, input logic d, input logic [7:0] b);
      wait_idle(i);
      tx[i] = 1'b1; dci[i] = d; dat[i] = b;
      cyc();
      tx[i] = 1'b0;
   endtask

   typedef struct {
      int         inst;
      logic       dc;
      logic [7:0] data;
      int         exp_len;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vt[6];

   initial begin
      int f0, sel, n;
      vt[0] = '{0, 1'b0, 8'hC0, 34, 8'hC0};
      vt[1] = '{1, 1'b1, 8'hA5, 17, 8'hA5};
      vt[2] = '{0, 1'b1, 8'h5A, 34, 8'h5A};
      vt[3] = '{1, 1'b0, 8'hFF, 17, 8'hFF};
      vt[4] = '{0, 1'b0, 8'h01, 34, 8'h01};
      vt[5] = '{1, 1'b1, 8'h80, 17, 8'h80};

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tx[i] = 1'b0; dci[i] = 1'b0; dat[i] = 8'h00; frames[i] = 0;
         last_gap[i] = 0; last_len[i] = 0; last_byte[i] = 8'h00; last_dc[i] = 1'b0;
         model_reset(i); mon_reset(i);
      end
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      for (int i = 0; i < 2; i++) begin
         chk("rst_cs_n", csn[i], 1); chk("rst_sck", sck[i], 0); chk("rst_mosi", mosi[i], 0);
         chk("rst_busy", busy[i], 0); chk("rst_ovr", ovr[i], 0); chk("rst_dc", dco[i], 0);
      end

      // table-driven single frames
      for (int v = 0; v < 6; v++) begin
         f0 = frames[vt[v].inst];
         send(vt[v].inst, vt[v].dc, vt[v].data);
         wait_idle(vt[v].inst);
         cyc();
         chk("tbl_frames", frames[vt[v].inst], f0 + 1);
         chk("tbl_byte", last_byte[vt[v].inst], vt[v].exp_byte);
         chk("tbl_dc", last_dc[vt[v].inst], vt[v].dc);
         chk("tbl_busy_len", last_len[vt[v].inst], vt[v].exp_len);
      end

      // back-to-back: second byte issued the first cycle busy reads 0
      f0 = frames[0];
      send(0, 1'b0, 8'h2A);
      send(0, 1'b1, 8'h00);
      wait_idle(0);
      cyc();
      chk("b2b_frames", frames[0], f0 + 2);
      chk("b2b_gap_ok", (last_gap[0] >= 1), 1);
      chk("b2b_last", last_byte[0], 8'h00);

      // overrun: second request 5 cycles into the first byte is dropped
      chk("ovr_pre", ovr[0], 0);
      f0 = frames[0];
      send(0, 1'b0, 8'h3C);
      repeat (4) cyc();
      tx[0] = 1'b1; dat[0] = 8'h77; dci[0] = 1'b1;
      cyc();
      tx[0] = 1'b0;
      chk("ovr_set", ovr[0], 1);
      wait_idle(0);
      repeat (10) cyc();
      chk("ovr_frames", frames[0], f0 + 1);
      chk("ovr_byte", last_byte[0], 8'h3C);
      chk("ovr_sticky", ovr[0], 1);

      // abort after the 4th SCK rise of 8'hFF
      send(0, 1'b1, 8'hFF);
      n = 0;
      while (mon_n[0] < 4 && n < 100) begin cyc(); n++; end
      chk("abort_reach4", mon_n[0], 4);
      rst = 1'b1;
      #1;
      chk("abort_cs_n", csn[0], 1);
      chk("abort_sck", sck[0], 0);
      chk("abort_busy", busy[0], 0);
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
      chk("abort_ovr_clr", ovr[0], 0);
      f0 = frames[0];
      send(0, 1'b0, 8'hB4);
      wait_idle(0);
      cyc();
      chk("abort_frames", frames[0], f0 + 1);
      chk("abort_byte", last_byte[0], 8'hB4);

      // reset held 3 cycles mid-byte, then 50 quiet cycles
      send(1, 1'b1, 8'hA5);
      repeat (3) cyc();
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (50) cyc();
      chk("quiet_cs_n", csn[1], 1); chk("quiet_sck", sck[1], 0);
      chk("quiet_mosi", mosi[1], 0); chk("quiet_busy", busy[1], 0);
      chk("quiet_dc", dco[1], 0);

      // randomized traffic including requests while busy
      for (int r = 0; r < 60; r++) begin
         sel = int'($urandom_range(0, 1));
         tx[sel] = 1'b1; dci[sel] = 1'($urandom); dat[sel] = 8'($urandom);
         cyc();
         tx[sel] = 1'b0;
         n = int'($urandom_range(0, 40));
         repeat (n) cyc();
      end
      wait_idle(0);
      wait_idle(1);
      repeat (3) cyc();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tft_spi_tx.md
# tft_spi_tx

Byte-level SPI transmitter at the display end of the TFT command path. Accepts one byte at a time with its data/command flag from the init sequencer or the pixel streamer over a transmit/busy handshake. Serialises the byte MSB-first onto the display's 4-wire SPI pins (mode 0). Owns chip select and the D/C line.

## Interface
- CLK_DIV, default 2: clk cycles per SCK half-period; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tft_transmit  input  1  single-cycle request; sampled only while tft_busy=0.
- tft_dc  input  1  0=command, 1=data; captured with the request.
- tft_data  input  8  byte to send; captured with the request.
- tft_busy  output  1  high while a byte is in flight.
- overrun  output  1  sticky; set when tft_transmit=1 while tft_busy=1.
- spi_sck  output  1  serial clock, idle low.
- spi_mosi  output  1  serial data, MSB first.
- spi_cs_n  output  1  chip select, active low.
- spi_dc  output  1  D/C pin to the panel.

## Operation
- Reset values: tft_busy=0, overrun=0, spi_sck=0, spi_mosi=0, spi_cs_n=1, spi_dc=0; state IDLE; counters 0.
- States:
  - IDLE: cs_n=1, sck=0. On tft_transmit=1, latch tft_data into an 8-bit shift register and tft_dc into spi_dc. Drive spi_mosi=tft_data[7]. Go to LOW; bit counter=0.
  - LOW: sck=0 for CLK_DIV cycles, then HIGH.
  - HIGH: sck=1 for CLK_DIV cycles.
    - On exit with bit counter<7: shift left, mosi=next bit, counter+1, go to LOW.
    - On exit with counter=7: go to HOLD.
  - HOLD: sck=0, cs_n=0 for CLK_DIV cycles, then IDLE.
- spi_mosi changes only on the LOW entry cycle (falling SCK edge or start), so the panel samples a stable bit on the rising edge.
- spi_dc holds the latched value until the next accepted request; it does not return to 0 in IDLE.
- Requests are accepted only when the FSM is in IDLE and tft_busy=0.
  - tft_transmit while tft_busy=1 is dropped.
  - That cycle overrun is set; it clears only on rst.
- Divider counter width is $clog2(CLK_DIV+1); bit counter is 3 bits. The divider counter reloads at every state change; no wrap-around between bytes.
- rst mid-byte aborts immediately: cs_n=1 and sck=0 on the asynchronous assert, and the partial byte is lost.

## Timing
- Request at cycle T (busy=0).
  - T+1: tft_busy=1, spi_cs_n=0, spi_dc and spi_mosi valid, sck=0.
  - First sck rise at T+1+CLK_DIV.
  - Bit n (7..0) sck high during cycles T+1+(2(7-n)+1)·CLK_DIV .. +CLK_DIV-1.
- tft_busy is high for exactly 17·CLK_DIV cycles. It falls together with cs_n rising at T+1+17·CLK_DIV.
- Earliest next accepted request is the cycle tft_busy reads 0. Back-to-back bytes therefore have at least one IDLE cycle with cs_n=1.
- tft_busy rises the cycle after tft_transmit. An upstream that waits on (~tft_busy & ~tft_transmit) never overruns.
- CLK_DIV=2: byte time 34 cycles, SCK = clk/4.

## Structure
- Shared package tft_pkg holds the state encoding (IDLE, LOW, HIGH, HOLD), the DC encoding constants (DC_COMM=0, DC_DATA=1) and the default CLK_DIV.
- Sub-module tft_spi_tick is a reloadable down-counter. It asserts a one-cycle tick after CLK_DIV cycles. The FSM uses it for every phase.
- Remaining logic lives in one module: FSM, shift register, bit counter and output registers, all registered with no combinational outputs.

## Test plan
- Reset: hold rst 3 cycles mid-stream → cs_n=1, sck=0, mosi=0, busy=0, overrun=0. Release rst with no request → outputs unchanged 50 cycles.
- Single command: CLK_DIV=2, transmit dc=0 data=8'hC0 at T.
  - busy high T+1..T+34.
  - cs_n low over the same window.
  - Sampled bits on the 8 sck rises = 1,1,0,0,0,0,0,0.
  - spi_dc=0 throughout.
- Data byte CLK_DIV=1: dc=1 data=8'hA5 → 8 sck pulses of 1-cycle high, bits 10100101, spi_dc=1, busy 17 cycles.
- Back-to-back: driver sends 8'h2A then 8'h00 as soon as busy=0.
  - At least one cycle of cs_n=1 between bytes.
  - Both bytes decoded correctly by the bench SPI monitor.
- Overrun: pulse transmit at T and again at T+5 → second byte never appears on MOSI, overrun=1 from T+6 until rst.
- Abort: rst asserted after the 4th sck rise of 8'hFF → cs_n=1 immediately. A new request after release sends a full, correct 8-bit frame.
